// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. It holds the PC, issues word-sequential fetch
// requests to an in-order instruction memory, and buffers the returned words
// in a small FIFO together with the PC each word belongs to. A credit check
// (requests in flight plus buffered words) keeps the FIFO from overflowing.
// A redirect or a taken branch flushes the FIFO, reloads the PC and arranges
// for every response still in flight to be discarded when it arrives.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous reset, active low
//   redirect_valid absolute redirect request (jump/exception)
//   redirect_pc    redirect target
//   br_z, br_b     branch is taken when both are high
//   br_pc          PC of the branch instruction
//   br_off         signed branch offset, in words
//   imem_req       fetch request valid
//   imem_addr      fetch address (current PC)
//   imem_gnt       memory accepts the request this cycle
//   imem_rvalid    response valid (in order, latency >= 1)
//   imem_rdata     response data
//   if_valid       FIFO head valid
//   if_ready       consumer accepts the head
//   if_instr       head instruction (0 when if_valid is low)
//   if_pc          head PC (0 when if_valid is low)
// ---------------------------------------------------------------------------
module fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                OFF_W    = 16,
    parameter int                QDEPTH   = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              br_z,
    input  logic              br_b,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [OFF_W-1:0]  br_off,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [DATA_W-1:0] if_instr,
    output logic [ADDR_W-1:0] if_pc
);

    localparam int              PW        = $clog2(QDEPTH);
    localparam int              CW        = PW + 1;
    localparam logic [CW:0]     DEPTH_LIM = (CW+1)'(QDEPTH);

    logic [ADDR_W-1:0] pc_reg;
    logic [ADDR_W-1:0] rsp_pc_reg;
    logic [CW-1:0]     outst_reg;
    logic [CW-1:0]     cnt_reg;
    logic [CW-1:0]     drop_reg;
    logic [PW-1:0]     wr_ptr_reg;
    logic [PW-1:0]     rd_ptr_reg;

    logic [DATA_W-1:0] instr_mem [QDEPTH];
    logic [ADDR_W-1:0] pc_mem    [QDEPTH];

    logic              flush;
    logic [ADDR_W-1:0] br_off_ext;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] flush_target;
    logic              credit_ok;
    logic              issue;
    logic              drop_rsp;
    logic              push;
    logic              pop;
    logic [CW-1:0]     outst_next;
    logic [CW-1:0]     cnt_next;

    assign flush        = redirect_valid | (br_z & br_b);
    assign br_off_ext   = {{(ADDR_W-OFF_W){br_off[OFF_W-1]}}, br_off};
    assign br_target    = br_pc + ADDR_W'(4) + (br_off_ext << 2);
    assign flush_target = redirect_valid ? redirect_pc : br_target;

    // Every word in flight has a FIFO slot reserved for it, so a response
    // can always be pushed without back-pressuring the memory.
    assign credit_ok = ({1'b0, outst_reg} + {1'b0, cnt_reg}) < DEPTH_LIM;
    // The reset term keeps the request low while reset is held, since the
    // credit check alone would already allow a request then.
    assign imem_req  = credit_ok & ~flush & reset;
    assign imem_addr = pc_reg;

    assign issue    = imem_req & imem_gnt;
    assign drop_rsp = imem_rvalid & (drop_reg != '0);
    assign push     = imem_rvalid & (drop_reg == '0) & ~flush;
    assign pop      = if_valid & if_ready & ~flush;

    // Every response retires one outstanding request, dropped or not.
    assign outst_next = outst_reg + CW'(issue) - CW'(imem_rvalid);
    assign cnt_next   = cnt_reg + CW'(push) - CW'(pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg     <= RESET_PC;
            rsp_pc_reg <= RESET_PC;
            outst_reg  <= '0;
            cnt_reg    <= '0;
            drop_reg   <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            outst_reg <= outst_next;
            if (flush) begin
                pc_reg     <= flush_target;
                rsp_pc_reg <= flush_target;
                cnt_reg    <= '0;
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                // Everything still in flight belongs to the old stream; a
                // response landing this very cycle is already accounted for.
                drop_reg   <= outst_reg - CW'(imem_rvalid);
            end else begin
                cnt_reg <= cnt_next;
                if (issue) begin
                    pc_reg <= pc_reg + ADDR_W'(4);
                end
                if (drop_rsp) begin
                    drop_reg <= drop_reg - CW'(1);
                end
                if (push) begin
                    wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    rsp_pc_reg <= rsp_pc_reg + ADDR_W'(4);
                end
                if (pop) begin
                    rd_ptr_reg <= rd_ptr_reg + PW'(1);
                end
            end
        end
    end

    // Storage is left unreset; only entries below cnt_reg are ever visible.
    always_ff @(posedge clk) begin
        if (push & reset) begin
            instr_mem[wr_ptr_reg] <= imem_rdata;
            pc_mem[wr_ptr_reg]    <= rsp_pc_reg;
        end
    end

    assign if_valid = (cnt_reg != '0);
    assign if_instr = if_valid ? instr_mem[rd_ptr_reg] : '0;
    assign if_pc    = if_valid ? pc_mem[rd_ptr_reg]    : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//
// Drives fetch_queue with an in-order memory model of random latency and a
// mix of directed and random redirects / branches. A reference model tracks
// the expected fetch PC, the requests in flight (tagged with a flush epoch)
// and the words the consumer should see; a monitor compares the DUT outputs
// against it every cycle.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int          ADDR_W   = 32;
    localparam int          DATA_W   = 32;
    localparam int          OFF_W    = 16;
    localparam int          QDEPTH   = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              redirect_valid = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic              br_z = 1'b0;
    logic              br_b = 1'b0;
    logic [31:0]       br_pc = '0;
    logic [15:0]       br_off = '0;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_gnt = 1'b0;
    logic              imem_rvalid = 1'b0;
    logic [31:0]       imem_rdata = '0;
    logic              if_valid;
    logic              if_ready = 1'b0;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;

    always #5 clk = ~clk;

    fetch_queue #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .OFF_W   (OFF_W),
        .QDEPTH  (QDEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .br_z          (br_z),
        .br_b          (br_b),
        .br_pc         (br_pc),
        .br_off        (br_off),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_deliv = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory content is a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic flush_in();
        return redirect_valid | (br_z & br_b);
    endfunction

    function automatic logic [31:0] flush_target();
        int off;
        off = $signed(br_off);
        if (redirect_valid) return redirect_pc;
        return br_pc + 32'd4 + 32'(off * 4);
    endfunction

    // ---------------- in-order memory with random latency ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mem_pipe[$];
    int unsigned lat_lo = 1;
    int unsigned lat_hi = 1;
    int          n_accepts = 0;

    always @(negedge clk) begin
        if (reset && imem_req && imem_gnt) begin
            mem_pipe.push_back('{addr: imem_addr, due: cyc + int'($urandom_range(lat_hi, lat_lo))});
            n_accepts++;
        end
    end

    always @(posedge clk) begin
        #1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        if (reset && mem_pipe.size() > 0 && mem_pipe[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_pipe[0].addr);
            void'(mem_pipe.pop_front());
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
    } infl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    infl_t       inflight[$];
    item_t       exp_q[$];
    logic [31:0] m_pc  = RESET_PC;
    int          epoch = 0;

    logic        s_rst, s_issue, s_rv, s_flush;
    logic [31:0] s_tgt;
    infl_t       e;

    always begin
        @(negedge clk);
        s_rst   = reset;
        s_issue = imem_req & imem_gnt;
        s_rv    = imem_rvalid;
        s_flush = flush_in();
        s_tgt   = flush_target();
        @(posedge clk);
        if (!s_rst) begin
            inflight.delete();
            exp_q.delete();
            m_pc  = RESET_PC;
            epoch = 0;
        end else begin
            if (s_rv) begin
                if (inflight.size() == 0) begin
                    chk("rsp_without_req", 32'(inflight.size()), 32'd1);
                end else begin
                    e = inflight.pop_front();
                    // Responses to requests issued before the latest flush
                    // never reach the consumer.
                    if (e.epoch == epoch && !s_flush)
                        exp_q.push_back('{pc: e.addr, instr: mem_word(e.addr)});
                end
            end
            if (s_issue) begin
                inflight.push_back('{addr: m_pc, epoch: epoch});
                m_pc = m_pc + 32'd4;
            end
            if (s_flush) begin
                epoch++;
                m_pc = s_tgt;
                exp_q.delete();
            end
            if (exp_q.size() > QDEPTH)
                chk("queue_overflow", 32'(exp_q.size()), 32'(QDEPTH));
        end
    end

    // ---------------- monitor ----------------
    logic exp_req;

    always @(negedge clk) begin
        if (reset) begin
            exp_req = (inflight.size() + exp_q.size() < QDEPTH) && !flush_in();
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("if_pc", if_pc, exp_q[0].pc);
                chk("if_instr", if_instr, exp_q[0].instr);
                if (if_ready && !flush_in()) begin
                    $display("[TB] pop pc=%08h instr=%08h", if_pc, if_instr);
                    void'(exp_q.pop_front());
                    n_deliv++;
                end
            end else begin
                chk("if_pc_idle", if_pc, 32'h0);
                chk("if_instr_idle", if_instr, 32'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_flush();
        redirect_valid = 1'b0;
        br_z           = 1'b0;
        br_b           = 1'b0;
    endtask

    task automatic quiesce();
        logic idle;
        step();
        imem_gnt = 1'b0;
        if_ready = 1'b1;
        clear_flush();
        idle = 1'b0;
        for (int i = 0; i < 80 && !idle; i++) begin
            @(negedge clk);
            if (mem_pipe.size() == 0 && !imem_rvalid && !if_valid && exp_q.size() == 0)
                idle = 1'b1;
        end
        chk("quiesce_timeout", 32'(idle), 32'd1);
    endtask

    int unsigned r;
    int          a0;
    int          d0;
    logic        seen;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_if_valid", 32'(if_valid), 32'd0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);

        // Release with a granting memory and a ready consumer.
        step();
        reset    = 1'b1;
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        #1;
        chk("first_req", 32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, RESET_PC);
        repeat (10) step();
        d0 = n_deliv;
        repeat (10) step();
        chk("steady_rate", 32'(n_deliv - d0), 32'd10);

        // Stalled consumer: credits run out after QDEPTH requests.
        quiesce();
        step();
        if_ready = 1'b0;
        imem_gnt = 1'b1;
        a0 = n_accepts;
        repeat (10) step();
        #1;
        chk("stall_req_low", 32'(imem_req), 32'd0);
        chk("stall_issued", 32'(n_accepts - a0), 32'(QDEPTH));
        chk("stall_full", 32'(if_valid), 32'd1);
        step();
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        repeat (4) step();
        #1;
        chk("one_pop_one_req", 32'(n_accepts - a0), 32'(QDEPTH + 1));
        chk("refill_req_low", 32'(imem_req), 32'd0);

        // Redirect with three requests in flight.
        quiesce();
        lat_lo = 5;
        lat_hi = 5;
        step();
        if_ready = 1'b0;
        imem_gnt = 1'b1;
        step();
        step();
        step();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("redirect_req_low", 32'(imem_req), 32'd0);
        step();
        clear_flush();
        imem_gnt = 1'b1;
        if_ready = 1'b1;
        lat_lo   = 1;
        lat_hi   = 1;
        #1;
        chk("redirect_addr", imem_addr, 32'h100);
        chk("redirect_empty", 32'(if_valid), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            if (if_valid) seen = 1'b1;
        end
        chk("redirect_seen", 32'(seen), 32'd1);
        chk("redirect_first_pc", if_pc, 32'h100);

        // Branch not taken, then taken with a negative offset.
        quiesce();
        step();
        imem_gnt = 1'b1;
        br_z     = 1'b1;
        br_b     = 1'b0;
        br_pc    = 32'h40;
        br_off   = 16'hFFFE;
        #1;
        chk("br_not_taken_req", 32'(imem_req), 32'd1);
        step();
        br_b = 1'b1;
        #1;
        chk("br_taken_req_low", 32'(imem_req), 32'd0);
        step();
        clear_flush();
        #1;
        chk("br_target", imem_addr, 32'h3C);

        // Redirect and taken branch together: the redirect wins.
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        br_z           = 1'b1;
        br_b           = 1'b1;
        br_pc          = 32'h80;
        br_off         = 16'h0005;
        step();
        clear_flush();
        #1;
        chk("redirect_priority", imem_addr, 32'h200);

        // PC wrap-around.
        quiesce();
        step();
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        clear_flush();
        #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        step();
        #1;
        chk("wrap_addr1", imem_addr, 32'hFFFF_FFFC);
        step();
        #1;
        chk("wrap_addr2", imem_addr, 32'h0000_0000);

        // Random traffic with occasional flushes.
        lat_lo = 1;
        lat_hi = 4;
        for (int i = 0; i < 2500; i++) begin
            step();
            imem_gnt = ($urandom_range(3, 0) != 0);
            if_ready = ($urandom_range(3, 0) != 0);
            r = $urandom_range(31, 0);
            redirect_valid = (r == 0);
            redirect_pc    = $urandom() & 32'hFFFF_FFFC;
            br_pc          = $urandom() & 32'hFFFF_FFFC;
            br_off         = 16'($urandom());
            if (r <= 1) begin
                br_z = 1'b1;
                br_b = 1'b1;
            end else if (r == 2) begin
                br_z = 1'b0;
                br_b = 1'b1;
            end else begin
                br_z = 1'($urandom_range(1, 0));
                br_b = 1'b0;
            end
        end

        quiesce();
        chk("delivered_count", 32'(n_deliv > 500), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, 32, address and PC width.
REQ-002 Parameter DATA_W, 32, instruction width.
REQ-003 Parameter OFF_W, 16, signed branch word-offset width; OFF_W <= ADDR_W-2.
REQ-004 Parameter QDEPTH, 4, instruction queue depth; power of 2, >= 2.
REQ-005 Parameter RESET_PC, 0, PC loaded on reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 redirect_valid  in  1  absolute redirect (jump/exception) request.
REQ-009 redirect_pc  in  ADDR_W  redirect target.
REQ-010 br_z, br_b  in  1 each  branch taken when br_z & br_b.
REQ-011 br_pc  in  ADDR_W  PC of the branch instruction.
REQ-012 br_off  in  OFF_W  signed word offset.
REQ-013 imem_req  out  1  fetch request valid.
REQ-014 imem_addr  out  ADDR_W  fetch address (current PC).
REQ-015 imem_gnt  in  1  memory accepts request this cycle.
REQ-016 imem_rvalid, imem_rdata  in  1, DATA_W  in-order response, any latency >= 1 cycle.
REQ-017 if_valid  out  1  queue head valid.
REQ-018 if_ready  in  1  consumer accepts head.
REQ-019 if_instr, if_pc  out  DATA_W, ADDR_W  head instruction and its PC.

Function
REQ-020 The block SHALL hold a PC register; a request is issued when imem_req & imem_gnt, after which PC <= PC + 4 (mod 2^ADDR_W).
REQ-021 The block SHALL keep counters outst (issued, response not yet received) and cnt (queue occupancy), each 0..QDEPTH.
REQ-022 imem_req SHALL equal (outst + cnt < QDEPTH) & ~flush, combinationally; imem_addr SHALL equal PC.
REQ-023 flush SHALL equal redirect_valid | (br_z & br_b).
REQ-024 Flush target SHALL be redirect_pc when redirect_valid, else br_pc + 4 + (sign_extend(br_off) << 2), mod 2^ADDR_W; redirect has priority.
REQ-025 On flush: PC <= target, rsp_pc <= target, cnt <= 0, drop <= outst minus 1 if imem_rvalid that cycle; pop and push in that cycle SHALL be discarded.
REQ-026 First request to the target SHALL appear on imem_addr the cycle after flush.
REQ-027 A response arriving while drop > 0 SHALL be discarded and decrement drop and outst.
REQ-028 A response arriving with drop = 0 SHALL be pushed with PC rsp_pc, then rsp_pc <= rsp_pc + 4, outst decremented.
REQ-029 Credit rule guarantees no push when full; push to a full queue SHALL never occur.
REQ-030 if_valid SHALL equal (cnt != 0); pop when if_valid & if_ready & ~flush.
REQ-031 Simultaneous push and pop SHALL leave cnt unchanged; push into empty queue SHALL be visible on if_valid the next cycle (no bypass).
REQ-032 Read/write pointers SHALL wrap modulo QDEPTH.
REQ-033 if_instr and if_pc SHALL be 0 when if_valid = 0.
REQ-034 Simultaneous issue and response SHALL update outst by net 0.

Reset
REQ-035 While reset = 0: PC = rsp_pc = RESET_PC; outst = cnt = drop = 0; pointers 0; imem_req = 0; if_valid = 0; if_instr = if_pc = 0.
REQ-036 Reset asserted mid-operation SHALL abandon all state; responses after release are outside the contract.
REQ-037 First request SHALL issue in the first cycle after reset release with imem_gnt = 1, addr RESET_PC.

Verification
REQ-038 Reset release, gnt = 1, 1-cycle latency, if_ready = 1 -> imem_addr 0,4,8,...; if_pc 0,4,8 with matching data, one per cycle steady state.
REQ-039 if_ready = 0, gnt = 1 -> exactly QDEPTH (4) requests, then imem_req = 0; cnt = 4; one pop re-enables one request.
REQ-040 3 requests outstanding, redirect_valid with redirect_pc 0x100 -> queue empties, next 3 responses dropped, next if_pc = 0x100.
REQ-041 br_z = br_b = 1, br_pc 0x40, br_off -2 -> target 0x3C; br_z = 1, br_b = 0 -> no flush.
REQ-042 redirect_valid and taken branch same cycle -> redirect_pc wins.
REQ-043 PC 0xFFFFFFFC issued -> next imem_addr 0x00000000.
